// File: rtl/reg_write_scoreboard.sv
// Writer-side register hazard tracker: per-register outstanding-write counters
// drive the pipeline go signal (stall_n) for the IF/ID and ID/EX registers.
module reg_write_scoreboard #(
  parameter int unsigned NUM_REGS  = 8,
  parameter int unsigned ADDR_W    = 3,
  parameter int unsigned CNT_W     = 2,
  parameter int unsigned WB_BYPASS = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                issue_valid,
  input  logic                issue_wb_en,
  input  logic [ADDR_W-1:0]   issue_dest,
  input  logic                src1_used,
  input  logic [ADDR_W-1:0]   src1,
  input  logic                src2_used,
  input  logic [ADDR_W-1:0]   src2,
  input  logic                retire_en,
  input  logic [ADDR_W-1:0]   retire_dest,
  output logic                stall_n,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic [3:0]          outstanding,
  output logic                underflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]    cnt_q [NUM_REGS];
  logic [CNT_W-1:0]    cnt_d [NUM_REGS];
  logic [3:0]          outstanding_q, outstanding_d;
  logic                underflow_q, underflow_d;
  logic [NUM_REGS-1:0] busy_eff;
  logic                hazard;
  logic                accept;
  logic                retire_ok;
  logic                retire_bad;

  // A register whose last pending write retires this cycle is already free
  // to readers when the WB bypass is enabled.
  always_comb begin
    busy_eff = '0;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      busy_eff[r] = (cnt_q[r] != '0) &&
                    !((WB_BYPASS != 0) && retire_en &&
                      (retire_dest == ADDR_W'(r)) && (cnt_q[r] == CNT_W'(1)));
    end
  end

  always_comb begin
    hazard = (src1_used && (src1 != '0) && busy_eff[src1]) ||
             (src2_used && (src2 != '0) && busy_eff[src2]) ||
             (issue_wb_en && (issue_dest != '0) && (cnt_q[issue_dest] == CNT_MAX));
    stall_n = !reset || !(issue_valid && hazard);
  end

  // Writes to R0 are never recorded, so a retire to R0 is neither a
  // decrement nor an underflow.
  always_comb begin
    accept     = issue_valid && stall_n && issue_wb_en && (issue_dest != '0);
    retire_ok  = retire_en && (retire_dest != '0) && (cnt_q[retire_dest] != '0);
    retire_bad = retire_en && (retire_dest != '0) && (cnt_q[retire_dest] == '0);
  end

  always_comb begin
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = cnt_q[r];
      if (accept && (issue_dest == ADDR_W'(r)) &&
          !(retire_ok && (retire_dest == ADDR_W'(r)))) begin
        cnt_d[r] = cnt_q[r] + CNT_W'(1);
      end else if (retire_ok && (retire_dest == ADDR_W'(r)) &&
                   !(accept && (issue_dest == ADDR_W'(r)))) begin
        cnt_d[r] = cnt_q[r] - CNT_W'(1);
      end
    end
    outstanding_d = outstanding_q;
    if (accept && !retire_ok) begin
      outstanding_d = outstanding_q + 4'd1;
    end else if (retire_ok && !accept) begin
      outstanding_d = outstanding_q - 4'd1;
    end
    underflow_d = underflow_q || retire_bad;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= '0;
      end
      outstanding_q <= '0;
      underflow_q   <= 1'b0;
    end else begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      outstanding_q <= outstanding_d;
      underflow_q   <= underflow_d;
    end
  end

  always_comb begin
    busy_mask = '0;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      busy_mask[r] = (cnt_q[r] != '0);
    end
  end

  assign outstanding = outstanding_q;
  assign underflow   = underflow_q;

endmodule

// File: tb/tb_reg_write_scoreboard.sv
// Directed bench for reg_write_scoreboard with hand-computed expectations.
module tb_reg_write_scoreboard;

  logic       clock;
  logic       reset;
  logic       issue_valid, issue_wb_en;
  logic [2:0] issue_dest;
  logic       src1_used, src2_used;
  logic [2:0] src1, src2;
  logic       retire_en;
  logic [2:0] retire_dest;
  logic       stall_n;
  logic [7:0] busy_mask;
  logic [3:0] outstanding;
  logic       underflow;

  int errors = 0;
  int checks = 0;

  reg_write_scoreboard #(
    .NUM_REGS (8),
    .ADDR_W   (3),
    .CNT_W    (2),
    .WB_BYPASS(1)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .issue_valid(issue_valid),
    .issue_wb_en(issue_wb_en),
    .issue_dest (issue_dest),
    .src1_used  (src1_used),
    .src1       (src1),
    .src2_used  (src2_used),
    .src2       (src2),
    .retire_en  (retire_en),
    .retire_dest(retire_dest),
    .stall_n    (stall_n),
    .busy_mask  (busy_mask),
    .outstanding(outstanding),
    .underflow  (underflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    issue_valid = 0; issue_wb_en = 0; issue_dest = 0;
    src1_used = 0; src1 = 0; src2_used = 0; src2 = 0;
    retire_en = 0; retire_dest = 0;
  endtask

  task automatic issue(input logic [2:0] dest);
    idle();
    issue_valid = 1; issue_wb_en = 1; issue_dest = dest;
  endtask

  initial begin
    idle();
    reset = 0;
    #1;
    check("rst_stall_n", stall_n, 1);
    check("rst_busy", busy_mask, 8'h00);
    check("rst_outst", outstanding, 0);
    check("rst_uflow", underflow, 0);
    step();
    reset = 1;
    step();

    // RAW stall on R3, released by WB bypass
    issue(3);
    #1 check("raw_issue_go", stall_n, 1);
    step();
    check("raw_busy", busy_mask, 8'h08);
    check("raw_outst", outstanding, 1);
    idle();
    issue_valid = 1; src1_used = 1; src1 = 3;
    #1 check("raw_stall0", stall_n, 0);
    step();
    check("raw_stall1", stall_n, 0);
    step();
    check("raw_stall2", stall_n, 0);
    check("raw_hold_busy", busy_mask, 8'h08);
    retire_en = 1; retire_dest = 3;
    #1 check("raw_bypass_go", stall_n, 1);
    step();
    check("raw_ret_busy", busy_mask, 8'h00);
    check("raw_ret_outst", outstanding, 0);

    // R0 and unused sources
    issue(0);
    step();
    check("r0_outst", outstanding, 0);
    check("r0_busy", busy_mask, 8'h00);
    issue(5);
    step();
    check("r5_busy", busy_mask, 8'h20);
    idle();
    issue_valid = 1; src1_used = 1; src1 = 0; src2_used = 0; src2 = 5;
    #1 check("r0_src_nostall", stall_n, 1);
    src2_used = 1;
    #1 check("src2_used_stall", stall_n, 0);
    idle();
    retire_en = 1; retire_dest = 5;
    step();
    check("r5_ret_outst", outstanding, 0);

    // Saturation on R6
    issue(6);
    step(); step(); step();
    check("sat_outst", outstanding, 3);
    check("sat_busy", busy_mask, 8'h40);
    #1 check("sat_stall", stall_n, 0);
    step();
    check("sat_hold_outst", outstanding, 3);
    check("sat_still_stall", stall_n, 0);

    // Simultaneous issue and retire on R2
    issue(2);
    step();
    check("sim_pre_outst", outstanding, 4);
    retire_en = 1; retire_dest = 2;
    #1 check("sim_go", stall_n, 1);
    step();
    check("sim_busy", busy_mask, 8'h44);
    check("sim_outst", outstanding, 4);

    // Underflow, sticky
    idle();
    retire_en = 1; retire_dest = 4;
    #1 check("uf_pre", underflow, 0);
    step();
    check("uf_set", underflow, 1);
    check("uf_outst", outstanding, 4);
    idle();
    repeat (10) step();
    check("uf_sticky", underflow, 1);

    // Mid-run reset with cnt[3]=2
    issue(3);
    step(); step();
    check("mr_busy", busy_mask, 8'h4C);
    check("mr_outst", outstanding, 6);
    idle();
    issue_valid = 1; src1_used = 1; src1 = 3; retire_en = 1; retire_dest = 3;
    #1 check("mr_no_bypass_cnt2", stall_n, 0);
    retire_en = 0;
    #1 reset = 0;
    #1;
    check("mr_rst_busy", busy_mask, 8'h00);
    check("mr_rst_outst", outstanding, 0);
    check("mr_rst_uflow", underflow, 0);
    check("mr_rst_stall_n", stall_n, 1);
    step();
    reset = 1;
    #1 check("mr_rel_go", stall_n, 1);
    idle();
    retire_en = 1; retire_dest = 3;
    step();
    check("mr_post_uflow", underflow, 1);
    check("mr_post_outst", outstanding, 0);
    idle();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
